// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory-access stage.
//               FSM state encoding, RV32 load/store funct3 codes and the
//               byte-strobe helper used to position store lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte enables for an access of size funct3[1:0] at byte offset off.
  // Only called for legal, aligned accesses, so the shift never overflows.
  function automatic logic [3:0] strb_mask(input logic [2:0] funct3,
                                           input logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_ext
// Description : Combinational load-data extractor. Selects the addressed
//               byte/halfword lane of a read word and sign- or zero-extends.
// Ports       : i_rdata  - read word from the data bus
//               i_off    - byte offset addr[1:0]
//               i_funct3 - load size/sign code
//               o_data   - extended result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Bring the addressed lane down to bit 0
  assign w_shift = i_rdata >> {i_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory-access stage. Accepts one execute result per
//               handshake, runs a single-outstanding load/store on the data
//               bus, extends load data and hands {rd, data} to writeback.
//               Exports a load-use hazard indication for decode.
// Ports       : CLK/RSTN          - clock, synchronous active-low reset
//               EX_*              - execute result handshake and payload
//               MEM_*             - data-memory bus (req/ack)
//               WB_*              - writeback handshake and payload
//               MEM_HAZARD(_SEL)  - pending load and its rd
//               MEM_FAULT         - one-cycle misalign/illegal-funct3 pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int XCNT = 32,
  parameter int XLEN = 32
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     EX_VALID,
  output logic                     EX_READY,
  input  logic                     EX_LOAD,
  input  logic                     EX_STORE,
  input  logic [2:0]               EX_FUNCT3,
  input  logic [$clog2(XCNT)-1:0]  EX_RD,
  input  logic                     EX_RD_WRITE,
  input  logic [XLEN-1:0]          EX_ALU_RESULT,
  input  logic [XLEN-1:0]          EX_STORE_DATA,
  output logic                     MEM_REQ,
  output logic                     MEM_WE,
  output logic [XLEN-1:0]          MEM_ADDR,
  output logic [XLEN-1:0]          MEM_WDATA,
  output logic [3:0]               MEM_WSTRB,
  input  logic                     MEM_ACK,
  input  logic [XLEN-1:0]          MEM_RDATA,
  output logic                     WB_ENABLED,
  input  logic                     WB_READY,
  output logic [$clog2(XCNT)-1:0]  WB_WRITE_SEL,
  output logic [XLEN-1:0]          WB_WRITE_DATA,
  output logic                     MEM_HAZARD,
  output logic [$clog2(XCNT)-1:0]  MEM_HAZARD_SEL,
  output logic                     MEM_FAULT
);

  localparam int RW = $clog2(XCNT);

  state_t          r_state, w_state_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]      r_mem_wstrb, w_mem_wstrb_nxt;
  logic            r_wb_en, w_wb_en_nxt;
  logic [RW-1:0]   r_wb_sel, w_wb_sel_nxt;
  logic [XLEN-1:0] r_wb_data, w_wb_data_nxt;
  logic            r_hazard, w_hazard_nxt;
  logic [RW-1:0]   r_hazard_sel, w_hazard_sel_nxt;
  logic            r_fault, w_fault_nxt;

  // Transaction context kept across ACCESS for load extraction and writeback
  logic            r_load;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [RW-1:0]   r_rd;
  logic            r_rd_write;

  logic            w_accept;
  logic            w_legal;
  logic            w_misal;
  logic            w_fault;
  logic            w_writes_rd;
  logic [XLEN-1:0] w_ext;

  assign EX_READY = (r_state == S_IDLE) && RSTN;
  assign w_accept = EX_VALID && EX_READY;
  assign w_writes_rd = EX_RD_WRITE && (EX_RD != '0);

  // funct3 legality depends on direction; both-high is always a fault
  always_comb begin
    w_legal = 1'b0;
    if (EX_LOAD) begin
      case (EX_FUNCT3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_legal = 1'b1;
        default:                             w_legal = 1'b0;
      endcase
    end else begin
      case (EX_FUNCT3)
        F3_SB, F3_SH, F3_SW: w_legal = 1'b1;
        default:             w_legal = 1'b0;
      endcase
    end
  end

  assign w_misal = ((EX_FUNCT3[1:0] == 2'b01) && EX_ALU_RESULT[0]) ||
                   ((EX_FUNCT3[1:0] == 2'b10) && (EX_ALU_RESULT[1:0] != 2'b00));
  assign w_fault = (EX_LOAD && EX_STORE) ||
                   ((EX_LOAD || EX_STORE) && (!w_legal || w_misal));

  mem_load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_rdata  (MEM_RDATA),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_wb_en_nxt      = r_wb_en;
    w_wb_sel_nxt     = r_wb_sel;
    w_wb_data_nxt    = r_wb_data;
    w_hazard_nxt     = r_hazard;
    w_hazard_sel_nxt = r_hazard_sel;
    w_fault_nxt      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault) begin
            w_fault_nxt = 1'b1;
          end else if (!EX_LOAD && !EX_STORE) begin
            w_state_nxt   = S_DONE;
            w_wb_en_nxt   = w_writes_rd;
            w_wb_sel_nxt  = w_writes_rd ? EX_RD : '0;
            w_wb_data_nxt = w_writes_rd ? EX_ALU_RESULT : '0;
          end else begin
            w_state_nxt      = S_ACCESS;
            w_mem_req_nxt    = 1'b1;
            w_mem_we_nxt     = EX_STORE;
            w_mem_addr_nxt   = {EX_ALU_RESULT[XLEN-1:2], 2'b00};
            w_mem_wdata_nxt  = EX_STORE ? (EX_STORE_DATA << {EX_ALU_RESULT[1:0], 3'b000}) : '0;
            w_mem_wstrb_nxt  = EX_STORE ? strb_mask(EX_FUNCT3, EX_ALU_RESULT[1:0]) : 4'b0000;
            w_hazard_nxt     = EX_LOAD && w_writes_rd;
            w_hazard_sel_nxt = (EX_LOAD && w_writes_rd) ? EX_RD : '0;
          end
        end
      end
      S_ACCESS: begin
        if (MEM_ACK) begin
          w_state_nxt     = S_DONE;
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
          w_mem_wstrb_nxt = 4'b0000;
          if (r_load && r_rd_write && (r_rd != '0)) begin
            w_wb_en_nxt   = 1'b1;
            w_wb_sel_nxt  = r_rd;
            w_wb_data_nxt = w_ext;
          end
        end
      end
      S_DONE: begin
        if (!r_wb_en || WB_READY) begin
          w_state_nxt      = S_IDLE;
          w_wb_en_nxt      = 1'b0;
          w_wb_sel_nxt     = '0;
          w_wb_data_nxt    = '0;
          w_hazard_nxt     = 1'b0;
          w_hazard_sel_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_wb_en      <= 1'b0;
      r_wb_sel     <= '0;
      r_wb_data    <= '0;
      r_hazard     <= 1'b0;
      r_hazard_sel <= '0;
      r_fault      <= 1'b0;
      r_load       <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_rd         <= '0;
      r_rd_write   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_wb_en      <= w_wb_en_nxt;
      r_wb_sel     <= w_wb_sel_nxt;
      r_wb_data    <= w_wb_data_nxt;
      r_hazard     <= w_hazard_nxt;
      r_hazard_sel <= w_hazard_sel_nxt;
      r_fault      <= w_fault_nxt;
      if (w_accept) begin
        r_load     <= EX_LOAD;
        r_funct3   <= EX_FUNCT3;
        r_off      <= EX_ALU_RESULT[1:0];
        r_rd       <= EX_RD;
        r_rd_write <= EX_RD_WRITE;
      end
    end
  end

  assign MEM_REQ        = r_mem_req;
  assign MEM_WE         = r_mem_we;
  assign MEM_ADDR       = r_mem_addr;
  assign MEM_WDATA      = r_mem_wdata;
  assign MEM_WSTRB      = r_mem_wstrb;
  assign WB_ENABLED     = r_wb_en;
  assign WB_WRITE_SEL   = r_wb_sel;
  assign WB_WRITE_DATA  = r_wb_data;
  assign MEM_HAZARD     = r_hazard;
  assign MEM_HAZARD_SEL = r_hazard_sel;
  assign MEM_FAULT      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage. Inputs change
//               and outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        EX_VALID, EX_READY, EX_LOAD, EX_STORE, EX_RD_WRITE;
  logic [2:0]  EX_FUNCT3;
  logic [4:0]  EX_RD;
  logic [31:0] EX_ALU_RESULT, EX_STORE_DATA;
  logic        MEM_REQ, MEM_WE, MEM_ACK;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [3:0]  MEM_WSTRB;
  logic        WB_ENABLED, WB_READY;
  logic [4:0]  WB_WRITE_SEL, MEM_HAZARD_SEL;
  logic [31:0] WB_WRITE_DATA;
  logic        MEM_HAZARD, MEM_FAULT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mem_stage #(.XCNT(32), .XLEN(32)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_LOAD(EX_LOAD), .EX_STORE(EX_STORE),
    .EX_FUNCT3(EX_FUNCT3), .EX_RD(EX_RD), .EX_RD_WRITE(EX_RD_WRITE),
    .EX_ALU_RESULT(EX_ALU_RESULT), .EX_STORE_DATA(EX_STORE_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WSTRB(MEM_WSTRB), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .WB_ENABLED(WB_ENABLED), .WB_READY(WB_READY), .WB_WRITE_SEL(WB_WRITE_SEL),
    .WB_WRITE_DATA(WB_WRITE_DATA), .MEM_HAZARD(MEM_HAZARD),
    .MEM_HAZARD_SEL(MEM_HAZARD_SEL), .MEM_FAULT(MEM_FAULT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Present one op for a single cycle; returns at the falling edge after accept
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [4:0] rd, input logic rdw,
                      input logic [31:0] alu, input logic [31:0] sd);
    EX_LOAD = ld; EX_STORE = st; EX_FUNCT3 = f3; EX_RD = rd;
    EX_RD_WRITE = rdw; EX_ALU_RESULT = alu; EX_STORE_DATA = sd;
    EX_VALID = 1'b1;
    step();
    EX_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTN = 1'b0; EX_VALID = 1'b0; EX_LOAD = 1'b0; EX_STORE = 1'b0; EX_FUNCT3 = 3'b000;
    EX_RD = 5'd0; EX_RD_WRITE = 1'b0; EX_ALU_RESULT = 32'h0; EX_STORE_DATA = 32'h0;
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0; WB_READY = 1'b1;
    step(); step();

    // Reset state
    chk("rst_ready",  32'(EX_READY),   32'd0);
    chk("rst_req",    32'(MEM_REQ),    32'd0);
    chk("rst_wb",     32'(WB_ENABLED), 32'd0);
    chk("rst_haz",    32'(MEM_HAZARD), 32'd0);
    chk("rst_fault",  32'(MEM_FAULT),  32'd0);
    chk("rst_wdata",  MEM_WDATA,       32'h0);
    RSTN = 1'b1;
    step();
    chk("rst_ready_up", 32'(EX_READY), 32'd1);

    // ALU op rd=5
    send(1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0);
    chk("alu_wb_en",   32'(WB_ENABLED),   32'd1);
    chk("alu_wb_sel",  32'(WB_WRITE_SEL), 32'd5);
    chk("alu_wb_data", WB_WRITE_DATA,     32'hDEADBEEF);
    chk("alu_ready_lo", 32'(EX_READY),    32'd0);
    chk("alu_noreq",   32'(MEM_REQ),      32'd0);
    step();
    chk("alu_ready_back", 32'(EX_READY),  32'd1);
    chk("alu_wb_clear",   32'(WB_ENABLED), 32'd0);

    // ALU op without rd write: DONE for one cycle, no writeback
    send(1'b0, 1'b0, 3'b000, 5'd6, 1'b0, 32'h11111111, 32'h0);
    chk("alu_nowr_wb",    32'(WB_ENABLED), 32'd0);
    chk("alu_nowr_ready", 32'(EX_READY),   32'd0);
    step();
    chk("alu_nowr_back",  32'(EX_READY),   32'd1);

    // SB at 0x1003
    send(1'b0, 1'b1, 3'b000, 5'd3, 1'b1, 32'h00001003, 32'h000000AB);
    chk("sb_req",   32'(MEM_REQ),   32'd1);
    chk("sb_we",    32'(MEM_WE),    32'd1);
    chk("sb_addr",  MEM_ADDR,       32'h00001000);
    chk("sb_strb",  32'(MEM_WSTRB), 32'h8);
    chk("sb_wdata", MEM_WDATA,      32'hAB000000);
    chk("sb_haz",   32'(MEM_HAZARD), 32'd0);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    chk("sb_req_drop", 32'(MEM_REQ),    32'd0);
    chk("sb_no_wb",    32'(WB_ENABLED), 32'd0);
    step();
    chk("sb_ready", 32'(EX_READY), 32'd1);

    // SH at 0x1002 and SW at 0x1000: strobe/lane placement
    send(1'b0, 1'b1, 3'b001, 5'd3, 1'b0, 32'h00001002, 32'h00001234);
    chk("sh_strb",  32'(MEM_WSTRB), 32'hC);
    chk("sh_wdata", MEM_WDATA,      32'h12340000);
    MEM_ACK = 1'b1; step(); MEM_ACK = 1'b0; step();
    send(1'b0, 1'b1, 3'b010, 5'd3, 1'b0, 32'h00001000, 32'hCAFEF00D);
    chk("sw_strb",  32'(MEM_WSTRB), 32'hF);
    chk("sw_wdata", MEM_WDATA,      32'hCAFEF00D);
    MEM_ACK = 1'b1; step(); MEM_ACK = 1'b0; step();

    // LB at 0x2001 with two wait cycles
    send(1'b1, 1'b0, 3'b000, 5'd7, 1'b1, 32'h00002001, 32'h0);
    chk("lb_req1",    32'(MEM_REQ),        32'd1);
    chk("lb_we",      32'(MEM_WE),         32'd0);
    chk("lb_strb",    32'(MEM_WSTRB),      32'h0);
    chk("lb_addr",    MEM_ADDR,            32'h00002000);
    chk("lb_haz",     32'(MEM_HAZARD),     32'd1);
    chk("lb_haz_sel", 32'(MEM_HAZARD_SEL), 32'd7);
    step();
    chk("lb_req2", 32'(MEM_REQ), 32'd1);
    step();
    chk("lb_req3", 32'(MEM_REQ), 32'd1);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h00008000;
    step();
    MEM_ACK = 1'b0;
    chk("lb_req_drop", 32'(MEM_REQ),      32'd0);
    chk("lb_wb_en",    32'(WB_ENABLED),   32'd1);
    chk("lb_wb_sel",   32'(WB_WRITE_SEL), 32'd7);
    chk("lb_wb_data",  WB_WRITE_DATA,     32'hFFFFFF80);
    chk("lb_haz_done", 32'(MEM_HAZARD),   32'd1);
    step();
    chk("lb_haz_clr", 32'(MEM_HAZARD), 32'd0);
    chk("lb_ready",   32'(EX_READY),   32'd1);

    // LBU same address, zero-wait ACK, writeback stalled two cycles
    send(1'b1, 1'b0, 3'b100, 5'd7, 1'b1, 32'h00002001, 32'h0);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0; WB_READY = 1'b0;
    chk("lbu_wb_data", WB_WRITE_DATA, 32'h00000080);
    step();
    chk("lbu_stall_en",    32'(WB_ENABLED), 32'd1);
    chk("lbu_stall_data",  WB_WRITE_DATA,   32'h00000080);
    chk("lbu_stall_ready", 32'(EX_READY),   32'd0);
    WB_READY = 1'b1;
    step();
    chk("lbu_ready", 32'(EX_READY),   32'd1);
    chk("lbu_wb_lo", 32'(WB_ENABLED), 32'd0);

    // LH at 0x2002: upper halfword, negative
    send(1'b1, 1'b0, 3'b001, 5'd9, 1'b1, 32'h00002002, 32'h0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h80010000;
    step();
    MEM_ACK = 1'b0;
    chk("lh_wb_data", WB_WRITE_DATA, 32'hFFFF8001);
    step();

    // Faults: misaligned LW, illegal funct3, load+store, misaligned LH
    send(1'b1, 1'b0, 3'b010, 5'd4, 1'b1, 32'h00003002, 32'h0);
    chk("lw_mis_fault", 32'(MEM_FAULT),  32'd1);
    chk("lw_mis_req",   32'(MEM_REQ),    32'd0);
    chk("lw_mis_ready", 32'(EX_READY),   32'd1);
    chk("lw_mis_haz",   32'(MEM_HAZARD), 32'd0);
    step();
    chk("lw_mis_pulse", 32'(MEM_FAULT),  32'd0);
    chk("lw_mis_nowb",  32'(WB_ENABLED), 32'd0);
    chk("lw_mis_req2",  32'(MEM_REQ),    32'd0);
    send(1'b1, 1'b0, 3'b011, 5'd4, 1'b1, 32'h00003000, 32'h0);
    chk("f3_ill_fault", 32'(MEM_FAULT), 32'd1);
    step();
    send(1'b1, 1'b1, 3'b000, 5'd4, 1'b1, 32'h00003000, 32'h0);
    chk("ldst_fault", 32'(MEM_FAULT), 32'd1);
    step();
    send(1'b0, 1'b1, 3'b100, 5'd4, 1'b1, 32'h00003000, 32'h0);
    chk("st_f3_fault", 32'(MEM_FAULT), 32'd1);
    step();
    send(1'b1, 1'b0, 3'b001, 5'd4, 1'b1, 32'h00003001, 32'h0);
    chk("lh_mis_fault", 32'(MEM_FAULT), 32'd1);
    chk("lh_mis_req",   32'(MEM_REQ),   32'd0);
    step();

    // LW rd=0: bus access happens, no writeback, no hazard
    send(1'b1, 1'b0, 3'b010, 5'd0, 1'b1, 32'h00004000, 32'h0);
    chk("lw0_req", 32'(MEM_REQ),    32'd1);
    chk("lw0_haz", 32'(MEM_HAZARD), 32'd0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h12345678;
    step();
    MEM_ACK = 1'b0;
    chk("lw0_wb",    32'(WB_ENABLED), 32'd0);
    chk("lw0_haz2",  32'(MEM_HAZARD), 32'd0);
    step();
    chk("lw0_ready", 32'(EX_READY), 32'd1);

    // Reset during ACCESS, then a stray ACK in IDLE
    send(1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 32'h00005000, 32'h0);
    chk("rma_req", 32'(MEM_REQ), 32'd1);
    RSTN = 1'b0;
    step();
    chk("rma_req_clr", 32'(MEM_REQ),    32'd0);
    chk("rma_haz_clr", 32'(MEM_HAZARD), 32'd0);
    RSTN = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFFFFFF;
    step();
    MEM_ACK = 1'b0;
    chk("rma_no_wb", 32'(WB_ENABLED), 32'd0);
    chk("rma_ready", 32'(EX_READY),   32'd1);
    step();
    chk("rma_no_wb2", 32'(WB_ENABLED), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the integer pipeline, sitting between execute and the register-file writeback block. Accepts one execute result per handshake, performs aligned load/store transactions on a single-outstanding data-memory bus, then sign/zero-extends load data. Presents `{rd, data}` to writeback with a valid/ready handshake. Also exports a load-use hazard indication for decode stall logic.

## Interface
- XCNT, 32, number of architectural registers; register index width is RW = clog2(XCNT)
- XLEN, 32, data width; byte-lane logic is defined for XLEN=32 only
- CLK  in  1  clock
- RSTN  in  1  reset, synchronous, active-low
- EX_VALID  in  1  execute result valid
- EX_READY  out  1  stage can accept; high only in IDLE with RSTN high
- EX_LOAD / EX_STORE  in  1  op is load / store; both low means ALU op; both high is illegal and gives a fault
- EX_FUNCT3  in  3  access size/sign, RV32 encoding
- EX_RD  in  RW  destination register
- EX_RD_WRITE  in  1  op writes rd
- EX_ALU_RESULT  in  XLEN  result for ALU ops, byte address for load/store
- EX_STORE_DATA  in  XLEN  rs2 value for stores
- MEM_REQ  out  1  bus request
- MEM_WE  out  1  store
- MEM_ADDR  out  XLEN  word address, low 2 bits always 0
- MEM_WDATA  out  XLEN  lane-positioned store data
- MEM_WSTRB  out  4  byte enables; 0 for loads
- MEM_ACK  in  1  transaction complete; MEM_RDATA valid for loads
- MEM_RDATA  in  XLEN  read word
- WB_ENABLED  out  1  writeback valid
- WB_READY  in  1  writeback accepts
- WB_WRITE_SEL  out  RW  register to write
- WB_WRITE_DATA  out  XLEN  value to write
- MEM_HAZARD  out  1  pending load targets MEM_HAZARD_SEL
- MEM_HAZARD_SEL  out  RW  rd of pending load
- MEM_FAULT  out  1  one-cycle pulse: misaligned address or illegal funct3

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE. All registered outputs are 0 in reset: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB, WB_ENABLED, WB_WRITE_SEL, WB_WRITE_DATA, MEM_FAULT, MEM_HAZARD, MEM_HAZARD_SEL.
- IDLE: on EX_VALID && EX_READY, latch all EX_* inputs.
  - ALU op: result = EX_ALU_RESULT; go to DONE.
  - Legal, aligned load/store: go to ACCESS.
  - Fault: pulse MEM_FAULT; stay in IDLE; no bus request, no writeback.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is a fault.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- ACCESS: hold MEM_REQ and all MEM_* outputs stable until MEM_ACK is sampled high.
  - Store: MEM_WSTRB = size mask (0001/0011/1111) << addr[1:0]; MEM_WDATA = data shifted left by 8*addr[1:0].
  - Load, on ACK: extract lane at addr[1:0], sign- or zero-extend, go to DONE.
  - Store, on ACK: go to DONE.
  - MEM_REQ drops on the edge that samples ACK.
- DONE:
  - WB_ENABLED = EX_RD_WRITE && rd != 0 && !store.
  - If WB_ENABLED: hold WB_WRITE_SEL/WB_WRITE_DATA until WB_READY; return to IDLE on the edge where WB_ENABLED && WB_READY.
  - If !WB_ENABLED: return to IDLE after one cycle.
- MEM_HAZARD: high from the accept edge of a load with rd != 0 and EX_RD_WRITE, until the edge leaving DONE.
- Reset mid-operation: next edge forces IDLE and clears outputs. An ACK arriving in IDLE is ignored.

## Timing
- Accept edge = T.
- ALU op: WB_ENABLED high at T+1. With WB_READY=1, EX_READY returns at T+2. Throughput is one ALU op per 2 cycles.
- Load/store: MEM_REQ high at T+1. Zero-wait ACK (high in cycle T+1) gives DONE at T+2. Each wait cycle adds one.
- Fault: MEM_FAULT high for the single cycle T+1. EX_READY stays high.
- WB_READY low in DONE: outputs stay frozen and EX_READY stays low.

## Structure
- Package `mem_pkg`: state enum, funct3 localparams (LB..LHU, SB..SW), function computing strobe mask from funct3 and addr[1:0].
- Sub-module `mem_load_ext` (combinational): MEM_RDATA, addr[1:0], funct3 -> extended XLEN value.

## Test plan
- ALU op, rd=5, result 0xDEADBEEF, WB_READY=1 -> WB_ENABLED at T+1 with SEL=5, DATA=0xDEADBEEF; EX_READY at T+2.
- SB at addr 0x1003, data 0xAB -> MEM_ADDR=0x1000, WSTRB=1000, WDATA[31:24]=0xAB, WE=1; no WB_ENABLED.
- LB at 0x2001, RDATA 0x0000_8000, 2 wait cycles -> MEM_REQ held 3 cycles; WB_WRITE_DATA=0xFFFFFF80; LBU of the same gives 0x80.
- LW at 0x3002 -> MEM_FAULT pulse at T+1, no MEM_REQ, no writeback, EX_READY high throughout.
- LW rd=0 -> bus transaction occurs; WB_ENABLED stays 0; MEM_HAZARD stays 0.
- RSTN low during ACCESS -> next edge: MEM_REQ=0, state IDLE; a following ACK produces no writeback.
